// File: rtl/lot_pkg.sv
// lot_pkg: shared gate FSM state encoding and default lot sizing.
package lot_pkg;
    localparam int DEFAULT_CAPACITY    = 25;
    localparam int DEFAULT_OPEN_CYCLES = 8;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_HOLDOFF = 2'd2
    } gate_state_e;
endpackage

// File: rtl/lot_controller_if.sv
// lot_controller_if: entry-gate arrival, gate sensor pulses and occupancy status bundle.
interface lot_controller_if import lot_pkg::*; #(parameter int CAPACITY = DEFAULT_CAPACITY) ();
    localparam int CW = $clog2(CAPACITY + 1);
    logic          car_arrive;
    logic          enter;
    logic          exit;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          gate_open;
    logic          reject;
    logic          err;
    modport master(output car_arrive, enter, exit, input count, full, empty, gate_open, reject, err);
    modport slave(input car_arrive, enter, exit, output count, full, empty, gate_open, reject, err);
endinterface

// File: rtl/occ_counter.sv
// occ_counter: saturating occupancy counter with sticky error on illegal enter/exit.
module occ_counter import lot_pkg::*; #(
    parameter int CAPACITY = DEFAULT_CAPACITY
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           inc_i,
    input  logic                           dec_i,
    output logic [$clog2(CAPACITY+1)-1:0]  count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           err_o
);
    localparam int CW = $clog2(CAPACITY + 1);
    localparam logic [CW-1:0] MAX = CW'(CAPACITY);
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          inc_only, dec_only;
    assign inc_only = inc_i & ~dec_i;
    assign dec_only = dec_i & ~inc_i;
    assign full_o   = count_q == MAX;
    assign empty_o  = count_q == '0;
    assign count_o  = count_q;
    assign err_o    = err_q;
    always_comb begin
        count_d = (inc_only & ~full_o)  ? count_q + CW'(1) :
                  (dec_only & ~empty_o) ? count_q - CW'(1) : count_q;
        err_d   = err_q | (inc_only & full_o) | (dec_only & empty_o);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: rtl/lot_controller.sv
// lot_controller: entry barrier FSM with open timeout and full-lot reject,
// tracking occupancy from external gate sensor enter/exit pulses.
module lot_controller import lot_pkg::*; #(
    parameter int CAPACITY    = DEFAULT_CAPACITY,
    parameter int OPEN_CYCLES = DEFAULT_OPEN_CYCLES
) (
    input logic             clk,
    input logic             reset,
    lot_controller_if.slave bus
);
    localparam int TW = $clog2(OPEN_CYCLES + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(OPEN_CYCLES);
    gate_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          full;
    occ_counter #(.CAPACITY(CAPACITY)) u_occ (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (bus.enter),
        .dec_i   (bus.exit),
        .count_o (bus.count),
        .full_o  (full),
        .empty_o (bus.empty),
        .err_o   (bus.err)
    );
    assign bus.full      = full;
    assign bus.gate_open = state_q == ST_OPEN;
    // Only the IDLE->HOLDOFF transition rejects, so a held arrival yields one pulse.
    assign bus.reject    = ~reset & (state_q == ST_IDLE) & bus.car_arrive & full;
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE, ST_HOLDOFF: begin
                if (bus.car_arrive && !full) begin
                    state_d = ST_OPEN;
                    timer_d = T_LOAD;
                end else if (bus.car_arrive) begin
                    state_d = ST_HOLDOFF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                timer_d = bus.enter ? '0 : timer_q - TW'(1);
                state_d = (bus.enter || timer_q == TW'(1)) ? ST_IDLE : ST_OPEN;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end
endmodule

// File: tb/tb_lot_controller.sv
// tb_lot_controller: scripted gate/occupancy scenarios with per-cycle expected outputs
// queued on drive and compared by a monitor mid-cycle.
module tb_lot_controller;
    localparam int CAP = 3;
    localparam int OC  = 8;
    typedef struct {
        int step;
        int cnt;
        bit g;
        bit r;
        bit e;
    } exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;
    logic clk      = 1'b0;
    logic reset    = 1'b1;
    lot_controller_if #(.CAPACITY(CAP)) bus();
    lot_controller #(.CAPACITY(CAP), .OPEN_CYCLES(OC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be during that cycle.
    task automatic cyc(bit rst, bit car, bit en, bit ex, int cnt, bit g, bit r, bit e);
        @(negedge clk);
        reset          = rst;
        bus.car_arrive = car;
        bus.enter      = en;
        bus.exit       = ex;
        sb.push_back('{step, cnt, g, r, e});
        step++;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check($sformatf("count@%0d", x.step), bus.count, x.cnt);
                check($sformatf("full@%0d", x.step), bus.full, x.cnt == CAP);
                check($sformatf("empty@%0d", x.step), bus.empty, x.cnt == 0);
                check($sformatf("gate_open@%0d", x.step), bus.gate_open, x.g);
                check($sformatf("reject@%0d", x.step), bus.reject, x.r);
                check($sformatf("err@%0d", x.step), bus.err, x.e);
            end
        end
    end

    initial begin
        bus.car_arrive = 1'b0;
        bus.enter      = 1'b0;
        bus.exit       = 1'b0;
        repeat (2) @(negedge clk);
        // reset state, then open on arrival and close on enter
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 2; i++) begin
            cyc(0, 1, 0, 0, i, 0, 0, 0);
            cyc(0, 0, 1, 0, i, 1, 0, 0);
        end
        cyc(0, 0, 0, 0, 3, 0, 0, 0);
        // full: held arrival rejects once, gate stays shut
        cyc(0, 1, 0, 0, 3, 0, 1, 0);
        repeat (4) cyc(0, 1, 0, 0, 3, 0, 0, 0);
        // exit frees a space while held in HOLDOFF
        cyc(0, 1, 0, 1, 3, 0, 0, 0);
        cyc(0, 1, 0, 0, 2, 0, 0, 0);
        cyc(0, 1, 0, 0, 2, 1, 0, 0);
        cyc(0, 0, 1, 0, 2, 1, 0, 0);
        cyc(0, 0, 0, 0, 3, 0, 0, 0);
        // arrival and exit together at full: judged on the pre-exit full
        cyc(0, 1, 0, 1, 3, 0, 1, 0);
        cyc(0, 1, 0, 0, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 2, 1, 0, 0);
        cyc(0, 0, 1, 0, 2, 1, 0, 0);
        cyc(0, 0, 0, 1, 3, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 0, 0, 0);
        // timeout: open exactly OC cycles without an enter
        cyc(0, 1, 0, 0, 1, 0, 0, 0);
        repeat (OC) cyc(0, 0, 0, 0, 1, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        // enter while idle still counts; simultaneous enter/exit holds count
        cyc(0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 2, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 1);
        // reset while open at count 2, with a coincident enter
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 2, 0, 0, 1);
        cyc(0, 1, 0, 0, 2, 1, 0, 1);
        cyc(1, 1, 1, 0, 2, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lot_controller.md
LOT_CONTROLLER -- requirements
Module: lot_controller

Interface
REQ-001 Parameter CAPACITY, default 25, maximum number of cars in the lot (1..255).
REQ-002 Parameter OPEN_CYCLES, default 8, entry barrier timeout in clock cycles (1..255).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 car_arrive  input  1  level; a car is waiting at the entry barrier.
REQ-006 enter  input  1  one-cycle pulse from the gate sensor FSM; a car completed entry.
REQ-007 exit  input  1  one-cycle pulse from the gate sensor FSM; a car completed exit.
REQ-008 count  output  CW=$clog2(CAPACITY+1)  current occupancy.
REQ-009 full  output  1  high when count == CAPACITY.
REQ-010 empty  output  1  high when count == 0.
REQ-011 gate_open  output  1  drive the entry barrier open.
REQ-012 reject  output  1  one-cycle pulse; an arrival was refused because the lot is full.
REQ-013 err  output  1  sticky; illegal enter at full or exit at empty occurred.

Function
REQ-014 Occupancy: count updates 1 cycle after the enter/exit pulse; enter only -> +1; exit only -> -1; both -> unchanged.
REQ-015 Saturation: enter alone at count==CAPACITY leaves count unchanged and sets err; exit alone at count==0 leaves count unchanged and sets err.
REQ-016 full and empty are combinational decodes of the registered count.
REQ-017 Gate FSM states: IDLE, OPEN, HOLDOFF.
REQ-018 IDLE: car_arrive & ~full -> OPEN, with the timer loaded to OPEN_CYCLES; car_arrive & full -> HOLDOFF with a reject pulse in the same cycle; otherwise remain in IDLE.
REQ-019 OPEN: gate_open=1; enter -> IDLE; timer expired (OPEN_CYCLES cycles in OPEN without enter) -> IDLE; timer decrements each cycle.
REQ-020 HOLDOFF: no further reject pulses; ~car_arrive -> IDLE; car_arrive & ~full (an exit freed a space) -> OPEN with the timer loaded.
REQ-021 gate_open is a Moore output, high exactly in the cycles where the FSM is in OPEN; it rises 1 cycle after qualifying car_arrive.
REQ-022 Exactly one reject pulse per refused arrival episode, even if car_arrive is held high.
REQ-023 Enter during OPEN while full is impossible by construction; if enter arrives in IDLE/HOLDOFF, the count is still updated per REQ-014 and the FSM state is unchanged.
REQ-024 An exit in the same cycle as an IDLE evaluation with full=1 uses the pre-update full value; the arrival goes to HOLDOFF and then opens next cycle per REQ-020.

Reset
REQ-025 On reset: count=0, FSM=IDLE, timer=0, err=0; outputs gate_open=0, reject=0, full=0, empty=1.
REQ-026 Reset mid-operation (any state, gate open) overrides everything in that cycle; enter/exit pulses coincident with reset are discarded.

Structure
REQ-027 Shared package lot_pkg holds the gate FSM state enum and the default CAPACITY/OPEN_CYCLES constants.
REQ-028 Sub-module occ_counter (parameter CAPACITY; inc, dec, count, err) implements REQ-014..016; the gate FSM and timer reside in lot_controller.
REQ-029 The gate sensor FSM instances are external; lot_controller consumes only their enter/exit pulses.

Verification
REQ-030 Reset, then car_arrive=1 -> gate_open high from the next cycle; enter pulse -> count 0->1, gate_open low next cycle.
REQ-031 CAPACITY=3: three arrive/enter sequences -> count=3, full=1; car_arrive held 5 cycles -> exactly one reject pulse, gate_open stays 0.
REQ-032 From REQ-031's HOLDOFF state with car_arrive still high, exit pulse -> count=2, gate opens on the following cycle.
REQ-033 car_arrive, no enter for OPEN_CYCLES=8 cycles -> gate_open high exactly 8 cycles, count unchanged.
REQ-034 count=2, enter and exit in the same cycle -> count stays 2, err=0; exit at count=0 -> count=0, err=1 held until reset.
REQ-035 Assert reset while in OPEN with count=2 -> next cycle count=0, gate_open=0, empty=1, err=0.
